// File: rtl/lfsr_rand_gen_pkg.sv
// Shared types and constants for the LFSR random source and its draw unit.
package lfsr_pkg;

  // Draw FSM: IDLE waits for a request, DRAW tries candidates until one fits.
  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_e;

  // Default 16-bit maximal-length feedback (bits 15,13,12,10) and start state.
  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'h0001;

  // Widest limit the mask helper handles; callers zero-extend and truncate.
  localparam int MASK_W = 32;

  // Smallest 2^k-1 covering limit-1 (fill ones below the top set bit).
  // limit==0 means the full range, so every bit is kept; limit==1 gives 0.
  function automatic logic [MASK_W-1:0] range_mask(input logic [MASK_W-1:0] limit);
    logic [MASK_W-1:0] top;
    logic [MASK_W-1:0] m;
    top = limit - MASK_W'(1);
    m   = '0;
    if (limit == '0) begin
      m = '1;
    end else begin
      for (int i = 0; i < MASK_W; i++) begin
        if ((top >> i) != '0) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_if.sv
// Requester-side bundle of the random source.
//
// Handshake: the requester raises req with limit while busy==0; the request
// is taken on that clock edge and busy rises. Exactly one valid pulse (one
// cycle) follows, carrying value; busy drops in that same cycle, so a new req
// may already be presented there. req while busy is dropped, never queued.
// seed_we/seed_in may be used on any cycle; lfsr_q is the raw state and
// dbg_state mirrors the draw FSM.
interface lfsr_rand_gen_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
) ();
  import lfsr_pkg::*;

  logic             seed_we;
  logic [WIDTH-1:0] seed_in;
  logic             req;
  logic [OUT_W-1:0] limit;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] value;
  logic [WIDTH-1:0] lfsr_q;
  draw_state_e      dbg_state;

  modport master (
    output seed_we, seed_in, req, limit,
    input  busy, valid, value, lfsr_q, dbg_state
  );

  modport slave (
    input  seed_we, seed_in, req, limit,
    output busy, valid, value, lfsr_q, dbg_state
  );
endinterface

// File: rtl/lfsr_rand_gen_core.sv
// Free-running Fibonacci LFSR with seed load and zero-state recovery.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_seed_we,
  input  logic [WIDTH-1:0] i_seed_in,
  output logic [WIDTH-1:0] o_lfsr_q
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic             w_fb;

  assign w_fb = ^(r_state & TAPS);

  // Next state: seed load wins; a zero seed or a zero state falls back to SEED
  // because an all-zero LFSR would lock up forever.
  always_comb begin
    w_next = {r_state[WIDTH-2:0], w_fb};
    if (i_seed_we) begin
      w_next = (i_seed_in == '0) ? SEED : i_seed_in;
    end else if (r_state == '0) begin
      w_next = SEED;
    end
  end

  // State register, steps on every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SEED;
    else        r_state <= w_next;
  end

  assign o_lfsr_q = r_state;

endmodule

// File: rtl/lfsr_rand_gen.sv
// Bounded-range random draw unit: masked rejection sampling on the LFSR low
// bits with a retry cap and a deterministic fallback.
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lfsr_rand_gen_if.slave  bus
);

  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  logic [WIDTH-1:0] w_lfsr_q;
  draw_state_e      r_state, w_state_d;
  logic [TRY_W-1:0] r_tries, w_tries_d;
  logic [OUT_W-1:0] r_limit, w_limit_d;
  logic             r_valid, w_valid_d;
  logic [OUT_W-1:0] r_value, w_value_d;
  logic [OUT_W-1:0] w_mask;
  logic [OUT_W-1:0] w_cand;
  logic             w_accept;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_seed_we (bus.seed_we),
    .i_seed_in (bus.seed_in),
    .o_lfsr_q  (w_lfsr_q)
  );

  // Candidate is the low LFSR bits masked to the smallest power-of-two range
  // holding limit-1; since mask < 2*limit, c - limit is in range on fallback.
  assign w_mask   = OUT_W'(range_mask(MASK_W'(r_limit)));
  assign w_cand   = w_lfsr_q[OUT_W-1:0] & w_mask;
  assign w_accept = (r_limit == '0) || (w_cand < r_limit);

  // Next-state and register-input logic for the draw FSM.
  always_comb begin
    w_state_d = r_state;
    w_tries_d = r_tries;
    w_limit_d = r_limit;
    w_valid_d = 1'b0;
    w_value_d = r_value;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_limit_d = bus.limit;
          w_tries_d = '0;
          w_state_d = DRAW;
        end
      end
      DRAW: begin
        if (w_accept) begin
          w_value_d = w_cand;
          w_valid_d = 1'b1;
          w_state_d = IDLE;
        end else if (r_tries == LAST_TRY) begin
          w_value_d = w_cand - r_limit;
          w_valid_d = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_tries_d = r_tries + TRY_W'(1);
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // Draw datapath registers: retry count, latched limit, result and pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tries <= '0;
      r_limit <= '0;
      r_valid <= 1'b0;
      r_value <= '0;
    end else begin
      r_tries <= w_tries_d;
      r_limit <= w_limit_d;
      r_valid <= w_valid_d;
      r_value <= w_value_d;
    end
  end

  assign bus.busy      = (r_state == DRAW);
  assign bus.valid     = r_valid;
  assign bus.value     = r_value;
  assign bus.lfsr_q    = w_lfsr_q;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: seed/step vector table, hand-written draw
// sequences, async reset mid-draw, and a full-period run with a draw model.
module tb_lfsr_rand_gen;
  import lfsr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_rand_gen_if #(.WIDTH(16), .OUT_W(8)) if0 ();
  lfsr_rand_gen_if #(.WIDTH(16), .OUT_W(8)) if1 ();

  lfsr_rand_gen #(
    .WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .OUT_W(8), .MAX_TRIES(8)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  lfsr_rand_gen #(
    .WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .OUT_W(8), .MAX_TRIES(1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [15:0] seed;
    logic [15:0] exp_lfsr;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if0.seed_we = 1'b0; if0.seed_in = '0; if0.req = 1'b0; if0.limit = '0;
    if1.seed_we = 1'b0; if1.seed_in = '0; if1.req = 1'b0; if1.limit = '0;
  endtask

  task automatic drive0(input logic req, input logic [7:0] lim,
                        input logic we, input logic [15:0] seed);
    if0.req = req; if0.limit = lim; if0.seed_we = we; if0.seed_in = seed;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] step_model(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Draw with limit 200: 199 needs all 8 bits, so the candidate is the raw
  // low byte. s is the state the first attempt sees.
  task automatic model_draw200(input logic [15:0] s_in, output logic [7:0] v, output int k);
    logic [15:0] s;
    logic [7:0]  c;
    s = s_in;
    v = '0;
    k = 8;
    for (int j = 1; j <= 8; j++) begin
      c = s[7:0];
      if (c < 8'd200) begin
        v = c; k = j;
        break;
      end
      if (j == 8) v = c - 8'd200;
      s = step_model(s);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int          err;
    logic [15:0] m_q;
    int          rem, acc_cyc, lat;
    logic        req_cur, exp_valid;
    logic [7:0]  ev;
    int          ek;
    int          trk_err, zero_cnt, early, vld_err, bsy_err, val_err, rng_err, lat_err, covered;
    bit          seen[200];

    vecs[0] = '{1'b0, 16'h0000, 16'h0002};
    vecs[1] = '{1'b0, 16'h0000, 16'h0004};
    vecs[2] = '{1'b1, 16'h0000, 16'h0001};
    vecs[3] = '{1'b1, 16'hACE1, 16'hACE1};
    vecs[4] = '{1'b0, 16'h0000, 16'h59C3};
    vecs[5] = '{1'b0, 16'h0000, 16'hB387};
    vecs[6] = '{1'b1, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{1'b0, 16'h0000, 16'hFFFE};
    vecs[8] = '{1'b1, 16'h8000, 16'h8000};
    vecs[9] = '{1'b0, 16'h0000, 16'h0001};

    // Reset state
    apply_reset();
    chk("rst_lfsr",     32'(if0.lfsr_q), 32'h0001);
    chk("rst_busy",     32'(if0.busy), 32'd0);
    chk("rst_valid",    32'(if0.valid), 32'd0);
    chk("rst_value",    32'(if0.value), 32'd0);
    chk("rst_state",    32'(if0.dbg_state), 32'(IDLE));
    chk("rst_lfsr_mt1", 32'(if1.lfsr_q), 32'h0001);

    // Stepping and seed-load vectors
    for (int i = 0; i < 10; i++) begin
      drive0(1'b0, 8'd0, vecs[i].we, vecs[i].seed);
      tick();
      chk($sformatf("vec%0d_lfsr", i), 32'(if0.lfsr_q), 32'(vecs[i].exp_lfsr));
    end
    drive_idle();

    // limit=0 draw on seed 0xACE1, then back-to-back limit=1 draw
    drive0(1'b1, 8'd0, 1'b1, 16'hACE1);
    tick();                                   // E0
    drive0(1'b0, 8'd0, 1'b0, 16'h0000);
    chk("full_busy", 32'(if0.busy), 32'd1);
    tick();                                   // E0+1
    chk("full_valid", 32'(if0.valid), 32'd1);
    chk("full_value", 32'(if0.value), 32'hE1);
    chk("full_idle",  32'(if0.busy), 32'd0);
    drive0(1'b1, 8'd1, 1'b0, 16'h0000);      // new req in the valid cycle
    tick();
    drive0(1'b0, 8'd0, 1'b0, 16'h0000);
    chk("b2b_busy",  32'(if0.busy), 32'd1);
    chk("b2b_novld", 32'(if0.valid), 32'd0);
    chk("b2b_hold",  32'(if0.value), 32'hE1);
    tick();
    chk("lim1_valid", 32'(if0.valid), 32'd1);
    chk("lim1_value", 32'(if0.value), 32'd0);
    chk("lim1_idle",  32'(if0.busy), 32'd0);
    tick();
    chk("lim1_pulse", 32'(if0.valid), 32'd0);

    // Reseed mid-draw: 254 rejected, then 0x10 accepted on the new sequence
    drive0(1'b1, 8'd200, 1'b1, 16'h00FE);
    tick();                                   // E0
    drive0(1'b0, 8'd0, 1'b1, 16'h0010);
    tick();                                   // E0+1
    chk("reseed_busy",  32'(if0.busy), 32'd1);
    chk("reseed_novld", 32'(if0.valid), 32'd0);
    drive_idle();
    tick();                                   // E0+2
    chk("reseed_valid", 32'(if0.valid), 32'd1);
    chk("reseed_value", 32'(if0.value), 32'd16);
    tick();

    // Eight rejections then fallback 254-200=54; a req mid-draw is dropped
    drive0(1'b1, 8'd200, 1'b1, 16'h00FE);
    tick();                                   // E0
    err = 0;
    for (int j = 1; j <= 7; j++) begin
      if (j == 3) drive0(1'b1, 8'd5, 1'b1, 16'h00FE);
      else        drive0(1'b0, 8'd0, 1'b1, 16'h00FE);
      tick();                                 // E0+j
      if (!(if0.valid == 1'b0 && if0.busy == 1'b1)) err++;
    end
    chk("fb8_wait", 32'(err), 32'd0);
    drive_idle();
    tick();                                   // E0+8
    chk("fb8_valid", 32'(if0.valid), 32'd1);
    chk("fb8_value", 32'(if0.value), 32'd54);
    chk("fb8_idle",  32'(if0.busy), 32'd0);
    tick();
    chk("fb8_noqueue_vld",  32'(if0.valid), 32'd0);
    chk("fb8_noqueue_busy", 32'(if0.busy), 32'd0);

    // MAX_TRIES=1: seed and req on the same edge, immediate fallback
    if1.seed_we = 1'b1; if1.seed_in = 16'h00FE; if1.req = 1'b1; if1.limit = 8'd200;
    tick();
    drive_idle();
    chk("mt1_busy", 32'(if1.busy), 32'd1);
    tick();
    chk("mt1_valid", 32'(if1.valid), 32'd1);
    chk("mt1_value", 32'(if1.value), 32'd54);
    chk("mt1_idle",  32'(if1.busy), 32'd0);

    // Async reset in the middle of a draw
    drive0(1'b1, 8'd200, 1'b1, 16'h00FE);
    tick();
    drive_idle();
    tick();
    chk("rstmid_pre_busy", 32'(if0.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy",  32'(if0.busy), 32'd0);
    chk("rstmid_valid", 32'(if0.valid), 32'd0);
    chk("rstmid_value", 32'(if0.value), 32'd0);
    chk("rstmid_lfsr",  32'(if0.lfsr_q), 32'h0001);
    chk("rstmid_state", 32'(if0.dbg_state), 32'(IDLE));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_restart", 32'(if0.lfsr_q), 32'h0002);
    err = 0;
    for (int j = 0; j < 11; j++) begin
      tick();
      if (if0.valid !== 1'b0) err++;
    end
    chk("rstmid_no_valid", 32'(err), 32'd0);

    // Full period with random req traffic, limit 200 while idle
    apply_reset();
    m_q = 16'h0001;
    rem = 0; acc_cyc = 0;
    trk_err = 0; zero_cnt = 0; early = 0; vld_err = 0; bsy_err = 0;
    val_err = 0; rng_err = 0; lat_err = 0;
    for (int i = 0; i < 200; i++) seen[i] = 1'b0;
    exp_q.delete();
    req_cur = 1'b1;
    drive0(req_cur, 8'd200, 1'b0, 16'h0000);
    for (int n = 1; n <= 65535; n++) begin
      tick();
      m_q = step_model(m_q);
      if (if0.lfsr_q !== m_q) trk_err++;
      if (if0.lfsr_q == 16'h0000) zero_cnt++;
      if (n < 65535 && if0.lfsr_q == 16'h0001) early++;
      exp_valid = (rem == 1);
      if (rem > 0) begin
        rem--;
      end else if (req_cur) begin
        model_draw200(m_q, ev, ek);
        exp_q.push_back(ev);
        rem = ek;
        acc_cyc = n;
      end
      if (if0.valid !== exp_valid) vld_err++;
      if (if0.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          val_err++;
        end else begin
          ev = exp_q.pop_front();
          if (if0.value !== ev) val_err++;
        end
        if (if0.value >= 8'd200) rng_err++;
        else seen[if0.value] = 1'b1;
        lat = n - acc_cyc;
        if (lat < 1 || lat > 8) lat_err++;
      end
      if (if0.busy !== (rem > 0)) bsy_err++;
      req_cur = ($urandom_range(0, 3) != 0);
      drive0(req_cur, (rem == 0) ? 8'd200 : 8'($urandom_range(0, 255)), 1'b0, 16'h0000);
    end
    drive_idle();
    covered = 0;
    for (int i = 0; i < 200; i++) if (seen[i]) covered++;
    chk("period_end",    32'(if0.lfsr_q), 32'h0001);
    chk("period_early",  32'(early), 32'd0);
    chk("never_zero",    32'(zero_cnt), 32'd0);
    chk("lfsr_track",    32'(trk_err), 32'd0);
    chk("valid_timing",  32'(vld_err), 32'd0);
    chk("busy_track",    32'(bsy_err), 32'd0);
    chk("value_model",   32'(val_err), 32'd0);
    chk("value_range",   32'(rng_err), 32'd0);
    chk("latency_range", 32'(lat_err), 32'd0);
    chk("coverage_200",  32'(covered), 32'd200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
